// File: rtl/noc_params.sv
// Shared NoC parameters and the flit payload carried between routers.
package noc_params;

  localparam int unsigned VC_NUM    = 2;
  localparam int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned DATA_SIZE = 16;

  typedef struct packed {
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_SIZE-1:0] data;
  } flit_t;

endpackage

// File: rtl/vc_input_buffer_vc_fifo_slice.sv
// One virtual-channel FIFO: storage, wrap-by-compare pointers, count and
// registered status, plus per-cycle accept/overflow/underflow strobes.
module vc_fifo_slice
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned PIPELINE_DEPTH = 5,
  localparam int unsigned CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  flit_t            data_i,
  output flit_t            data_c,
  output logic             is_full_o,
  output logic             is_empty_o,
  output logic             on_off_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             accept_c,
  output logic             overflow_c,
  output logic             underflow_c
);

  localparam int unsigned PTR_W    = $clog2(BUFFER_SIZE);
  localparam int unsigned LAST     = BUFFER_SIZE - 1;
  localparam int unsigned ON_LIMIT = BUFFER_SIZE - PIPELINE_DEPTH;

  flit_t             mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, on_off_q, on_off_d;
  logic              do_rd, do_wr;

  // A full slice still accepts a write when the same cycle pops it.
  always_comb begin
    do_rd       = rd_en && !empty_q;
    do_wr       = wr_en && (!full_q || do_rd);
    accept_c    = do_wr;
    overflow_c  = wr_en && !do_wr;
    underflow_c = rd_en && empty_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (do_rd) head_d = (head_q == PTR_W'(LAST)) ? '0 : head_q + PTR_W'(1);
    if (do_wr) tail_d = (tail_q == PTR_W'(LAST)) ? '0 : tail_q + PTR_W'(1);
    if (do_wr && !do_rd)      count_d = count_q + CNT_W'(1);
    else if (do_rd && !do_wr) count_d = count_q - CNT_W'(1);
    full_d   = (count_d == CNT_W'(BUFFER_SIZE));
    empty_d  = (count_d == '0);
    on_off_d = (count_d < CNT_W'(ON_LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      on_off_q <= 1'b1;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      on_off_q <= on_off_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[tail_q] <= data_i;
  end

  assign data_c      = mem_q[head_q];
  assign is_full_o   = full_q;
  assign is_empty_o  = empty_q;
  assign on_off_o    = on_off_q;
  assign occupancy_o = count_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Router input-port buffer: one FIFO slice per VC, write steered by vc_id,
// pop by explicit VC index, sticky overflow/underflow detection.
module vc_input_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned PIPELINE_DEPTH = 5,
  parameter int unsigned VC_NUM         = noc_params::VC_NUM,
  localparam int unsigned CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  flit_t                         data_i,
  input  logic                          write_i,
  input  logic                          read_i,
  input  logic [VC_SIZE-1:0]            read_vc_i,
  output flit_t                         data_o,
  output logic [VC_NUM-1:0]             is_full_o,
  output logic [VC_NUM-1:0]             is_empty_o,
  output logic [VC_NUM-1:0]             on_off_o,
  output logic [VC_NUM-1:0][CNT_W-1:0]  occupancy_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  if (BUFFER_SIZE <= PIPELINE_DEPTH) begin : g_bad_depth
    $error("vc_input_buffer: BUFFER_SIZE must exceed PIPELINE_DEPTH");
  end
  if (BUFFER_SIZE < 2 || VC_NUM < 1 || VC_NUM > (2 ** VC_SIZE)) begin : g_bad_size
    $error("vc_input_buffer: illegal BUFFER_SIZE or VC_NUM");
  end

  logic [VC_NUM-1:0] wr_en, rd_en, accept, slice_ovf, slice_ufl;
  flit_t             slice_data [VC_NUM];
  logic              overflow_q, overflow_d, underflow_q, underflow_d;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign wr_en[v] = write_i && (data_i.vc_id == VC_SIZE'(v));
    assign rd_en[v] = read_i && (read_vc_i == VC_SIZE'(v));

    vc_fifo_slice #(
      .BUFFER_SIZE   (BUFFER_SIZE),
      .PIPELINE_DEPTH(PIPELINE_DEPTH)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[v]),
      .rd_en      (rd_en[v]),
      .data_i     (data_i),
      .data_c     (slice_data[v]),
      .is_full_o  (is_full_o[v]),
      .is_empty_o (is_empty_o[v]),
      .on_off_o   (on_off_o[v]),
      .occupancy_o(occupancy_o[v]),
      .accept_c   (accept[v]),
      .overflow_c (slice_ovf[v]),
      .underflow_c(slice_ufl[v])
    );
  end

  // Head-of-queue mux; an out-of-range read VC shows zero.
  always_comb begin
    data_o = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (read_vc_i == VC_SIZE'(v)) data_o = slice_data[v];
    end
  end

  // A write nobody accepted covers out-of-range vc_id as well as full slices.
  always_comb begin
    overflow_d  = overflow_q | (|slice_ovf) | (write_i && !(|accept));
    underflow_d = underflow_q | (|slice_ufl) | (read_i && !(|rd_en));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomized bench for vc_input_buffer against a per-VC queue model.
module tb_vc_input_buffer;
  import noc_params::*;

  localparam int unsigned B     = 8;
  localparam int unsigned P     = 5;
  localparam int unsigned NV    = noc_params::VC_NUM;
  localparam int unsigned CNT_W = $clog2(B + 1);

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  flit_t                      data_i = '0;
  logic                       write_i = 1'b0;
  logic                       read_i = 1'b0;
  logic [VC_SIZE-1:0]         read_vc_i = '0;
  flit_t                      data_o;
  logic [NV-1:0]              is_full_o, is_empty_o, on_off_o;
  logic [NV-1:0][CNT_W-1:0]   occupancy_o;
  logic                       overflow_o, underflow_o;

  vc_input_buffer #(.BUFFER_SIZE(B), .PIPELINE_DEPTH(P), .VC_NUM(NV)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .read_i(read_i),
    .read_vc_i(read_vc_i), .data_o(data_o), .is_full_o(is_full_o),
    .is_empty_o(is_empty_o), .on_off_o(on_off_o), .occupancy_o(occupancy_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  flit_t mq [NV][$];
  bit    m_ovf = 1'b0;
  bit    m_ufl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input int unsigned vc, input int unsigned payload);
    flit_t f;
    f.vc_id = VC_SIZE'(vc);
    f.data  = DATA_SIZE'(payload);
    return f;
  endfunction

  // Queue-level model: pop first, then the write sees the freed slot.
  task automatic model_edge(input bit w, input flit_t d, input bit r, input int unsigned rv);
    bit popped = 1'b0;
    int unsigned wv = int'(d.vc_id);
    if (r) begin
      if (rv < NV && mq[rv].size() > 0) begin
        void'(mq[rv].pop_front());
        popped = 1'b1;
      end else m_ufl = 1'b1;
    end
    if (w) begin
      if (wv < NV && (mq[wv].size() < B || (popped && rv == wv))) mq[wv].push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit w, input flit_t d, input bit r, input int unsigned rv);
    write_i = w; data_i = d; read_i = r; read_vc_i = VC_SIZE'(rv);
    @(posedge clk);
    model_edge(w, d, r, rv);
    #1;
    write_i = 1'b0; read_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, 32'(is_empty_o), 32'({NV{1'b1}}));
    check({tag, "_full"}, 32'(is_full_o), 32'd0);
    check({tag, "_onoff"}, 32'(on_off_o), 32'({NV{1'b1}}));
    check({tag, "_occ"}, 32'(occupancy_o), 32'd0);
    check({tag, "_flags"}, {30'd0, overflow_o, underflow_o}, 32'd0);
  endtask

  // Every-cycle comparison of registered outputs and the head flit.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int v = 0; v < int'(NV); v++) begin
        check("occ", 32'(occupancy_o[v]), 32'(mq[v].size()));
        check("full", 32'(is_full_o[v]), 32'(mq[v].size() == B));
        check("empty", 32'(is_empty_o[v]), 32'(mq[v].size() == 0));
        check("on_off", 32'(on_off_o[v]), 32'(mq[v].size() < (B - P)));
      end
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      check("underflow", 32'(underflow_o), 32'(m_ufl));
      if (int'(read_vc_i) < int'(NV) && mq[read_vc_i].size() > 0)
        check("data_o", 32'(data_o), 32'(mq[read_vc_i][0]));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) step(1, mk(0, 'h100 + i), 0, 0);
    check("occ0_after3", 32'(occupancy_o[0]), 32'd3);
    check("onoff0_after3", 32'(on_off_o[0]), 32'd0);
    check("onoff1_after3", 32'(on_off_o[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      read_vc_i = '0;
      #1;
      check("pop_order_vc0", 32'(data_o.data), 32'('h100 + i));
      step(0, '0, 1, 0);
    end
    check("empty0_drained", 32'(is_empty_o[0]), 32'd1);
    check("onoff0_drained", 32'(on_off_o[0]), 32'd1);

    for (int i = 0; i < 8; i++) step(1, mk(1, 'h200 + i), 0, 1);
    check("ovf_before_9th", 32'(overflow_o), 32'd0);
    step(1, mk(1, 'h2FF), 0, 1);
    check("full1", 32'(is_full_o[1]), 32'd1);
    check("ovf_9th", 32'(overflow_o), 32'd1);
    check("occ1_full", 32'(occupancy_o[1]), 32'd8);

    for (int i = 0; i < 10; i++) step(1, mk(1, 'h300 + i), 1, 1);
    check("occ1_wrap", 32'(occupancy_o[1]), 32'd8);
    read_vc_i = VC_SIZE'(1);
    #1;
    check("head1_wrap", 32'(data_o.data), 32'h302);

    check("ufl_before", 32'(underflow_o), 32'd0);
    step(0, '0, 1, 0);
    check("ufl_empty_pop", 32'(underflow_o), 32'd1);
    check("occ0_ufl", 32'(occupancy_o[0]), 32'd0);
    check("occ1_ufl", 32'(occupancy_o[1]), 32'd8);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, mk($urandom_range(0, NV - 1), $urandom),
           $urandom_range(0, 1) == 1, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, mk($urandom_range(0, NV - 1), $urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, NV - 1));

    for (int i = 0; i < 4; i++) step(1, mk(i % 2, 'h400 + i), 0, 0);
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    for (int v = 0; v < int'(NV); v++) mq[v].delete();
    m_ovf = 1'b0;
    m_ufl = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) == 1, mk($urandom_range(0, NV - 1), $urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, NV - 1));
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Multi-virtual-channel input buffer for the router input port: one FIFO per VC behind a shared write/read interface, with per-VC full/empty status, on/off flow-control toward the upstream router, occupancy counters and sticky overflow/underflow flags. Incoming flits are steered by their `vc_id` field. The switch-allocation stage pops by explicit VC index. Generalises the single-queue circular buffer to `VC_NUM` channels and adds error detection and occupancy visibility.

## Interface
- `BUFFER_SIZE`, 8: slots per VC; any value ≥ 2, no power-of-two requirement.
- `PIPELINE_DEPTH`, 5: round-trip flits in flight after off is signalled; elaboration error unless `BUFFER_SIZE > PIPELINE_DEPTH`.
- `VC_NUM`, 2: number of virtual channels, ≥ 1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_i`  in  `flit_t`  incoming flit; target VC = `data_i.vc_id`.
- `write_i`  in  1  write strobe.
- `read_i`  in  1  pop strobe.
- `read_vc_i`  in  `VC_SIZE`  VC to pop / present on `data_o`.
- `data_o`  out  `flit_t`  head flit of VC `read_vc_i`, first-word fall-through.
- `is_full_o`  out  `VC_NUM`  per-VC full.
- `is_empty_o`  out  `VC_NUM`  per-VC empty.
- `on_off_o`  out  `VC_NUM`  per-VC on (1) / off (0) credit signal.
- `occupancy_o`  out  `VC_NUM × $clog2(BUFFER_SIZE+1)`  per-VC flit count.
- `overflow_o`  out  1  sticky: write to a full VC dropped.
- `underflow_o`  out  1  sticky: pop of an empty VC ignored.

## Operation
- Per VC: `head`, `tail` pointers in 0..BUFFER_SIZE-1 and count in 0..BUFFER_SIZE. Each pointer wraps to 0 after BUFFER_SIZE-1 by explicit compare.
- Write to VC v (`write_i`, v = `data_i.vc_id`):
  - Stores at `tail[v]`, advances tail, increments count.
  - If v is full and this cycle does not also pop v, the flit is dropped, state is unchanged and `overflow_o` is set.
- Pop (`read_i`) of VC r = `read_vc_i`:
  - Advances `head[r]` and decrements count.
  - If r is empty, state is unchanged and `underflow_o` is set.
- Simultaneous write v and pop r:
  - v ≠ r: both proceed independently.
  - v = r, non-empty: count unchanged; both pointers advance. This is legal even when full.
  - v = r, empty: pop is an underflow, write proceeds, count becomes 1.
- Flow control, per VC: `on_off_o[v]` = 1 iff registered count < `BUFFER_SIZE - PIPELINE_DEPTH`.
- `is_full_o[v]` = (count = BUFFER_SIZE); `is_empty_o[v]` = (count = 0).
- `data_o` = memory[r][head[r]], combinational on `read_vc_i`. It is undefined when VC r is empty.
- Sticky flags clear only on reset.
- Out-of-range VC index (≥ VC_NUM): write is dropped with `overflow_o` set; read is ignored with `underflow_o` set.

## Timing
- Writes and pops take effect on the rising edge. Status, occupancy and on/off outputs are registered and reflect the new state one cycle after the strobe.
- Write-to-`data_o` latency: 1 cycle (flit visible the cycle after the write edge if its VC was empty and selected).
- Reset values (asserted asynchronously, held while `rst`=0):
  - All pointers and counts 0.
  - `is_empty_o` all 1s, `is_full_o` 0, `on_off_o` all 1s.
  - `occupancy_o` 0, `overflow_o` 0, `underflow_o` 0.
  - Memory contents are not reset.
- Reset mid-operation discards all queued flits immediately.
- First accepted write is on the first rising edge after `rst` rises.

## Structure
- `flit_t`, `VC_SIZE`, and the flit field sizes belong in `noc_params`. No new typedefs.
- Sub-module `vc_fifo_slice`, one instance per VC via generate:
  - Holds memory, pointers, count and status for one VC.
  - Takes `wr_en`, `rd_en` and `data_i`; reports `accept`, `overflow` and `underflow` strobes.
- Top level:
  - Decodes the write VC and read VC.
  - Muxes `data_o`.
  - ORs the slice error strobes into the sticky flags.

## Test plan
- Reset, then write 3 flits to VC0 → `occupancy_o[0]`=3, `on_off_o[0]`=0 (threshold 3), `on_off_o[1]`=1; pop 3 from VC0 → flits come out in write order, `is_empty_o[0]`=1, `on_off_o[0]`=1.
- Fill VC1 with 8 flits, then write a 9th → `is_full_o[1]`=1, `overflow_o`=1, `occupancy_o[1]`=8, the 9th flit never appears.
- VC1 full, then simultaneous write and pop on VC1 for 10 cycles → count stays 8, pointers wrap, FIFO order preserved, no overflow.
- Interleave writes to VC0 and VC1 while popping VC1 → VC0 contents are unaffected; per-VC order is checked against a scoreboard queue per VC.
- Pop an empty VC0 → `underflow_o`=1 and counts unchanged; assert `rst`=0 mid-stream → all outputs return to their reset values before the next clock edge.
